adventure_move_sequencer: RTL and testbench

- Controller in front of the adventure-game room FSM (inputs n/s/e/w, outputs win/die).
- Arbitrates direction requests from two players and issues exactly one single-cycle move pulse at a time.
- Samples win/die after each move, latches the game result, and holds it for a fixed time.
- Then sequences a game restart by pulsing the room FSM's active-high reset.

---
 rtl/adventure_move_sequencer.sv | 120 ++++++++++++
 tb/tb_adventure_move_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/adventure_move_sequencer.sv
// Two-player move arbiter and game-result sequencer in front of the
// adventure room FSM: one move pulse at a time, result hold, then restart.
module adventure_move_sequencer #(
    parameter int MOVE_LIMIT     = 31,
    parameter int HOLD_CYCLES    = 8,
    parameter int RESTART_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] p0_dir,
    input  logic       p0_valid,
    output logic       p0_ready,
    input  logic [3:0] p1_dir,
    input  logic       p1_valid,
    output logic       p1_ready,
    input  logic       win,
    input  logic       die,
    output logic [3:0] game_dir,
    output logic       game_rst,
    output logic [7:0] move_count,
    output logic [1:0] result,
    output logic       bad_move,
    output logic       last_grant
);

    localparam logic [2:0] ACCEPT  = 3'd0;
    localparam logic [2:0] ISSUE   = 3'd1;
    localparam logic [2:0] SETTLE  = 3'd2;
    localparam logic [2:0] HOLD    = 3'd3;
    localparam logic [2:0] RESTART = 3'd4;

    logic [2:0]  state;
    logic [2:0]  state_n;
    logic [15:0] cnt;
    logic [3:0]  dir_q;
    logic        xfer0;
    logic        xfer1;
    logic        xfer;
    logic        sel0;
    logic        sel1;
    logic [3:0]  xdir;
    logic        xdir_ok;
    logic        at_limit;

    assign xfer0 = (state == ACCEPT) & p0_ready & p0_valid;
    assign xfer1 = (state == ACCEPT) & p1_ready & p1_valid;
    assign xfer  = xfer0 | xfer1;

    // On a tie the player that did not win last time gets the grant.
    assign sel1 = p1_valid & (~p0_valid | ~last_grant);
    assign sel0 = p0_valid & ~sel1;

    assign xdir     = xfer1 ? p1_dir : p0_dir;
    assign xdir_ok  = (|xdir) & ~(|(xdir & (xdir - 4'd1)));
    assign at_limit = (move_count == 8'(MOVE_LIMIT));

    assign game_dir = (state == ISSUE) ? dir_q : 4'b0000;
    assign game_rst = (state == RESTART);

    always_comb begin
        state_n = state;
        case (state)
            ACCEPT:  if (xfer && xdir_ok) state_n = ISSUE;
            ISSUE:   state_n = SETTLE;
            SETTLE:  state_n = (win | die | at_limit) ? HOLD : ACCEPT;
            HOLD:    if (cnt == 16'd1) state_n = RESTART;
            RESTART: if (cnt == 16'd1) state_n = ACCEPT;
            default: state_n = RESTART;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= RESTART;
            cnt        <= 16'(RESTART_CYCLES);
            dir_q      <= 4'b0000;
            p0_ready   <= 1'b0;
            p1_ready   <= 1'b0;
            move_count <= 8'd0;
            result     <= 2'b00;
            bad_move   <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state    <= state_n;
            // Ready is registered; requesters hold valid until it arrives.
            p0_ready <= (state_n == ACCEPT) & ~xfer & sel0;
            p1_ready <= (state_n == ACCEPT) & ~xfer & sel1;
            bad_move <= xfer & ~xdir_ok;
            if (xfer) begin
                last_grant <= xfer1;
                dir_q      <= xdir;
            end
            case (state)
                ISSUE: begin
                    if (move_count != 8'hff) move_count <= move_count + 8'd1;
                end
                SETTLE: begin
                    if (win)           result <= 2'b01;
                    else if (die)      result <= 2'b10;
                    else if (at_limit) result <= 2'b11;
                    cnt <= 16'(HOLD_CYCLES);
                end
                HOLD: begin
                    if (cnt == 16'd1) cnt <= 16'(RESTART_CYCLES);
                    else              cnt <= cnt - 16'd1;
                end
                RESTART: begin
                    if (cnt == 16'd1) begin
                        move_count <= 8'd0;
                        result     <= 2'b00;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adventure_move_sequencer.sv
// Scoreboard bench for adventure_move_sequencer: moves, arbitration,
// bad requests, win/die/timeout hold and restart, abort by reset.
module tb_adventure_move_sequencer;

    logic       clk;
    logic       reset;
    logic [3:0] p0_dir;
    logic       p0_valid;
    logic       p0_ready;
    logic [3:0] p1_dir;
    logic       p1_valid;
    logic       p1_ready;
    logic       win;
    logic       die;
    logic [3:0] game_dir;
    logic       game_rst;
    logic [7:0] move_count;
    logic [1:0] result;
    logic       bad_move;
    logic       last_grant;

    int errs   = 0;
    int checks = 0;
    logic [4:0] sb[$];
    logic [4:0] sb_exp;

    adventure_move_sequencer #(
        .MOVE_LIMIT(5),
        .HOLD_CYCLES(8),
        .RESTART_CYCLES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .p0_dir(p0_dir),
        .p0_valid(p0_valid),
        .p0_ready(p0_ready),
        .p1_dir(p1_dir),
        .p1_valid(p1_valid),
        .p1_ready(p1_ready),
        .win(win),
        .die(die),
        .game_dir(game_dir),
        .game_rst(game_rst),
        .move_count(move_count),
        .result(result),
        .bad_move(bad_move),
        .last_grant(last_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Each move or bad request shows up as {bad_move, game_dir} once.
    always @(negedge clk) begin
        if (game_dir != 4'd0 || bad_move) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", {27'd0, bad_move, game_dir}, 0);
            end else begin
                sb_exp = sb.pop_front();
                chk("sb_move", {27'd0, bad_move, game_dir}, {27'd0, sb_exp});
            end
        end
    end

    task automatic do_reset(input int n);
        int hi = 0;
        reset = 1'b0;
        repeat (n) @(negedge clk);
        chk("rst_game_rst", game_rst, 1);
        chk("rst_ready", {p0_ready, p1_ready}, 0);
        chk("rst_dir", game_dir, 0);
        chk("rst_count", move_count, 0);
        chk("rst_result", result, 0);
        chk("rst_bad", bad_move, 0);
        reset = 1'b1;
        for (int i = 0; i < 10 && game_rst; i++) begin
            hi++;
            @(negedge clk);
        end
        chk("rst_release_len", hi, 2);
        chk("rst_last_grant", last_grant, 1);
    endtask

    task automatic do_move(input bit pl, input logic [3:0] d,
                           input logic [7:0] cnt, input logic [1:0] res);
        bit seen = 0;
        if (pl) begin
            p1_dir = d;
            p1_valid = 1'b1;
        end else begin
            p0_dir = d;
            p0_valid = 1'b1;
        end
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = pl ? p1_ready : p0_ready;
        end
        if (!seen) begin
            chk("ready_timeout", 0, 1);
            p0_valid = 1'b0;
            p1_valid = 1'b0;
            return;
        end
        chk("ready_no_rst", game_rst, 0);
        sb.push_back(($countones(d) == 1) ? {1'b0, d} : 5'b10000);
        @(negedge clk);
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        chk("ready_1cyc", pl ? p1_ready : p0_ready, 0);
        @(negedge clk);
        chk("move_count", move_count, cnt);
        @(negedge clk);
        chk("result", result, res);
    endtask

    task automatic tie(input int n, input logic [7:0] cnt,
                       input logic [1:0] res);
        int k = 0;
        p0_dir = 4'b0010;
        p1_dir = 4'b0001;
        p0_valid = 1'b1;
        p1_valid = 1'b1;
        for (int i = 0; i < 100 && k < n; i++) begin
            @(negedge clk);
            if (p0_ready || p1_ready) begin
                chk("grant", p1_ready, k % 2);
                chk("both_ready", p0_ready & p1_ready, 0);
                sb.push_back((k % 2 == 1) ? 5'b00001 : 5'b00010);
                k++;
            end
        end
        if (k < n) chk("tie_timeout", k, n);
        @(negedge clk);
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        @(negedge clk);
        chk("tie_count", move_count, cnt);
        @(negedge clk);
        chk("tie_result", result, res);
    endtask

    // Called on the first HOLD cycle; a request is kept pending throughout.
    task automatic hold_restart(input logic [1:0] res);
        p0_dir = 4'b1000;
        p0_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("hold_result", result, res);
            chk("hold_ready", {p0_ready, p1_ready}, 0);
            chk("hold_rst", game_rst, 0);
            @(negedge clk);
        end
        for (int j = 0; j < 2; j++) begin
            chk("restart_rst", game_rst, 1);
            chk("restart_result", result, res);
            chk("restart_ready", {p0_ready, p1_ready}, 0);
            if (j == 1) p0_valid = 1'b0;
            @(negedge clk);
        end
        chk("after_rst", game_rst, 0);
        chk("after_result", result, 0);
        chk("after_count", move_count, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        p0_dir = 4'd0;
        p0_valid = 1'b0;
        p1_dir = 4'd0;
        p1_valid = 1'b0;
        win = 1'b0;
        die = 1'b0;
        do_reset(3);

        do_move(1'b0, 4'b1000, 8'd1, 2'b00);
        do_move(1'b1, 4'b0110, 8'd1, 2'b00);

        tie(4, 8'd5, 2'b11);
        hold_restart(2'b11);

        do_move(1'b0, 4'b0100, 8'd1, 2'b00);
        do_move(1'b0, 4'b0100, 8'd2, 2'b00);
        win = 1'b1;
        do_move(1'b0, 4'b0001, 8'd3, 2'b01);
        hold_restart(2'b01);

        die = 1'b1;
        do_move(1'b0, 4'b1000, 8'd1, 2'b01);
        hold_restart(2'b01);

        win = 1'b0;
        do_move(1'b1, 4'b0010, 8'd1, 2'b10);
        hold_restart(2'b10);

        do_move(1'b0, 4'b0100, 8'd1, 2'b10);
        repeat (2) @(negedge clk);
        die = 1'b0;
        do_reset(1);
        tie(2, 8'd2, 2'b00);

        repeat (2) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
